// File: rtl/display_bank_controller.sv
// Double-buffered 7-segment display bank: writes land in a shadow set and
// become visible only when committed into the active set.
module display_bank_controller #(
    parameter int NUM_DIGITS = 6,
    parameter int WORD_SIZE  = 8,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_en,
    input  logic [$clog2(NUM_DIGITS+3)-1:0]       wr_addr,
    input  logic [WORD_SIZE-1:0]                  wr_data,
    output logic                                  wr_err,
    input  logic                                  commit_req,
    output logic                                  commit_ack,
    output logic                                  dirty,
    output logic [NUM_DIGITS-1:0][6:0]            hex_out
);

    localparam int         CW      = $clog2(BLINK_DIV);
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [NUM_DIGITS-1:0][6:0] shadow_digit, active_digit, next_digit;
    logic [NUM_DIGITS-1:0]      shadow_mode, shadow_blink, shadow_blank;
    logic [NUM_DIGITS-1:0]      active_mode, active_blink, active_blank;
    logic [NUM_DIGITS-1:0]      next_mode, next_blink, next_blank;
    logic [NUM_DIGITS-1:0][6:0] resolved;
    logic [CW-1:0]              blink_cnt;
    logic                       blink_phase;
    logic                       addr_valid;
    logic                       write_hit;
    logic                       unused_data;

    // Only the low 7 data bits (digits) or NUM_DIGITS bits (masks) are stored.
    assign unused_data = ^wr_data;

    assign addr_valid = int'(wr_addr) < (NUM_DIGITS + 3);
    assign write_hit  = wr_en && addr_valid;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    // Shadow contents after this edge's write, so a same-edge commit sees it.
    always_comb begin
        next_digit = shadow_digit;
        next_mode  = shadow_mode;
        next_blink = shadow_blink;
        next_blank = shadow_blank;
        if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (int'(wr_addr) == i) next_digit[i] = wr_data[6:0];
            end
            if (int'(wr_addr) == NUM_DIGITS)     next_mode  = wr_data[NUM_DIGITS-1:0];
            if (int'(wr_addr) == NUM_DIGITS + 1) next_blink = wr_data[NUM_DIGITS-1:0];
            if (int'(wr_addr) == NUM_DIGITS + 2) next_blank = wr_data[NUM_DIGITS-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            logic [6:0] seg;
            seg = 7'h00;
            if (active_blank[i] || (active_blink[i] && blink_phase)) seg = 7'h00;
            else if (active_mode[i])                                   seg = active_digit[i];
            else                                                       seg = hex_decode(active_digit[i][3:0]);
            resolved[i] = (ACTIVE_LOW != 0) ? ~seg : seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digit <= '0;
            shadow_mode  <= '0;
            shadow_blink <= '0;
            shadow_blank <= '0;
            active_digit <= '0;
            active_mode  <= '0;
            active_blink <= '0;
            active_blank <= '0;
            dirty        <= 1'b0;
            wr_err       <= 1'b0;
            commit_ack   <= 1'b0;
        end else begin
            shadow_digit <= next_digit;
            shadow_mode  <= next_mode;
            shadow_blink <= next_blink;
            shadow_blank <= next_blank;
            if (commit_req) begin
                active_digit <= next_digit;
                active_mode  <= next_mode;
                active_blink <= next_blink;
                active_blank <= next_blank;
            end
            if (commit_req)     dirty <= 1'b0;
            else if (write_hit) dirty <= 1'b1;
            wr_err     <= wr_en && !addr_valid;
            commit_ack <= commit_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hex_out <= {NUM_DIGITS{SEG_OFF}};
        else        hex_out <= resolved;
    end

endmodule

// File: tb/tb_display_bank_controller.sv
// Directed bench for display_bank_controller: expectations queued at drive
// time, popped and compared once the DUT has produced the result.
module tb_display_bank_controller;

    localparam int NUM_DIGITS = 6;
    localparam int WORD_SIZE  = 8;
    localparam int BLINK_DIV  = 4;
    localparam int AW         = $clog2(NUM_DIGITS + 3);

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b1;
    logic                       wr_en = 1'b0;
    logic [AW-1:0]              wr_addr = '0;
    logic [WORD_SIZE-1:0]       wr_data = '0;
    logic                       commit_req = 1'b0;
    logic                       wr_err;
    logic                       commit_ack;
    logic                       dirty;
    logic [NUM_DIGITS-1:0][6:0] hex_out;

    int    assert_count = 0;
    int    fail_count   = 0;
    int    edge_count;
    string tag_q[$];
    logic [63:0] exp_q[$];

    display_bank_controller #(
        .NUM_DIGITS(NUM_DIGITS),
        .WORD_SIZE (WORD_SIZE),
        .BLINK_DIV (BLINK_DIV),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .commit_req(commit_req),
        .commit_ack(commit_ack),
        .dirty     (dirty),
        .hex_out   (hex_out)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; used to predict the blink phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_count <= 0;
        else        edge_count <= edge_count + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expectVal(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input logic [63:0] observed);
        string       tag;
        logic [63:0] expv;
        assert_count++;
        if (exp_q.size() == 0) begin
            fail_count++;
            $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", observed);
        end else begin
            tag  = tag_q.pop_front();
            expv = exp_q.pop_front();
            assert (observed === expv) else begin
                fail_count++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expv);
            end
        end
    endtask

    // Drives one cycle of stimulus from a falling edge and checks the flags
    // the DUT registers at the following rising edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] a,
                                 input logic [WORD_SIZE-1:0] d, input logic cr,
                                 input logic exp_dirty, input logic exp_ack,
                                 input logic exp_err, input string tag);
        expectVal({tag, "_dirty"}, 64'(exp_dirty));
        expectVal({tag, "_ack"},   64'(exp_ack));
        expectVal({tag, "_err"},   64'(exp_err));
        wr_en      = we;
        wr_addr    = a;
        wr_data    = d;
        commit_req = cr;
        @(negedge clk);
        wr_en      = 1'b0;
        commit_req = 1'b0;
        checkOutput(64'(dirty));
        checkOutput(64'(commit_ack));
        checkOutput(64'(wr_err));
    endtask

    task automatic checkHex(input string tag, input logic [41:0] v);
        expectVal(tag, 64'(v));
        checkOutput(64'(hex_out));
    endtask

    initial begin
        logic blink_off;

        #1 rst_n = 1'b0;
        @(negedge clk);
        checkHex("reset_hex", {6{7'h7F}});
        expectVal("reset_dirty", 64'd0); checkOutput(64'(dirty));
        expectVal("reset_ack",   64'd0); checkOutput(64'(commit_ack));
        expectVal("reset_err",   64'd0); checkOutput(64'(wr_err));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkHex("first_edge_hex", {6{7'h40}});

        // Hex glyph 8 on digit 0
        applyStimulus(1'b1, AW'(0), 8'h08, 1'b0, 1'b1, 1'b0, 1'b0, "wr_d0");
        checkHex("no_commit_hex", {6{7'h40}});
        applyStimulus(1'b0, AW'(0), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "commit1");
        @(negedge clk);
        expectVal("ack_drop", 64'd0); checkOutput(64'(commit_ack));
        checkHex("hex_eight", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00});

        // Raw mode on digit 1
        applyStimulus(1'b1, AW'(6), 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, "wr_mode");
        applyStimulus(1'b1, AW'(1), 8'h49, 1'b0, 1'b1, 1'b0, 1'b0, "wr_d1");
        checkHex("raw_uncommitted", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00});
        applyStimulus(1'b0, AW'(0), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "commit2");
        @(negedge clk);
        checkHex("hex_raw", {7'h40, 7'h40, 7'h40, 7'h40, 7'h36, 7'h00});

        // Write forwarded through a same-edge commit
        applyStimulus(1'b1, AW'(0), 8'h0A, 1'b1, 1'b0, 1'b1, 1'b0, "wr_commit");
        @(negedge clk);
        checkHex("hex_fwd", {7'h40, 7'h40, 7'h40, 7'h40, 7'h36, 7'h08});

        // Unmapped addresses
        applyStimulus(1'b1, AW'(9), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, "wr_bad9");
        applyStimulus(1'b1, AW'(15), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, "wr_bad15");
        @(negedge clk);
        expectVal("err_drop", 64'd0); checkOutput(64'(wr_err));

        // Commit held for two edges
        applyStimulus(1'b0, AW'(0), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "hold_a");
        applyStimulus(1'b0, AW'(0), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "hold_b");
        @(negedge clk);
        expectVal("hold_drop", 64'd0); checkOutput(64'(commit_ack));
        checkHex("hex_after_bad", {7'h40, 7'h40, 7'h40, 7'h40, 7'h36, 7'h08});

        // Blink digit 0 showing glyph 1
        applyStimulus(1'b1, AW'(7), 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, "wr_blink");
        applyStimulus(1'b1, AW'(0), 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, "wr_d0b");
        applyStimulus(1'b0, AW'(0), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "commit3");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            blink_off = (((edge_count - 1) / BLINK_DIV) % 2) == 1;
            checkHex("hex_blink", {7'h40, 7'h40, 7'h40, 7'h40, 7'h36,
                                   (blink_off ? 7'h7F : 7'h79)});
        end

        // Blank digit 1; bit 7 of the mask write is discarded
        applyStimulus(1'b1, AW'(7), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "clr_blink");
        applyStimulus(1'b1, AW'(8), 8'h82, 1'b0, 1'b1, 1'b0, 1'b0, "wr_blank");
        applyStimulus(1'b0, AW'(0), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "commit4");
        @(negedge clk);
        checkHex("hex_blank", {7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h79});

        // Reset between edges while dirty, with a commit pending
        applyStimulus(1'b1, AW'(2), 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, "wr_d2");
        wr_en      = 1'b1;
        wr_addr    = AW'(3);
        wr_data    = 8'h0F;
        commit_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkHex("midrst_hex", {6{7'h7F}});
        expectVal("midrst_dirty", 64'd0); checkOutput(64'(dirty));
        expectVal("midrst_phase", 64'd0); checkOutput(64'(dut.blink_phase));
        @(negedge clk);
        wr_en      = 1'b0;
        commit_req = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        checkHex("post_rst_hex", {6{7'h40}});
        applyStimulus(1'b0, AW'(0), 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "commit5");
        @(negedge clk);
        checkHex("post_rst_commit", {6{7'h40}});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/display_bank_controller.md
DISPLAY_BANK_CONTROLLER -- requirements
Module: display_bank_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 6: number of 7-segment digits driven; legal range 1..WORD_SIZE.
REQ-002 Parameter WORD_SIZE, default 8: write data width; at least 7.
REQ-003 Parameter BLINK_DIV, default 25_000_000: clock cycles per blink half-period; at least 2.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means a lit segment drives 0.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port wr_en, input, 1: write strobe, sampled each rising edge.
REQ-008 Port wr_addr, input, $clog2(NUM_DIGITS+3): shadow register address.
REQ-009 Port wr_data, input, WORD_SIZE: write data.
REQ-010 Port wr_err, output, 1: one-cycle pulse, write to an unmapped address.
REQ-011 Port commit_req, input, 1: request to copy the shadow set into the active set.
REQ-012 Port commit_ack, output, 1: one-cycle pulse confirming a commit.
REQ-013 Port dirty, output, 1: shadow written since the last commit.
REQ-014 Port hex_out, output, [NUM_DIGITS][7]: registered segment drive; bit0=a … bit6=g.

Function
REQ-015 Address map, addresses 0..NUM_DIGITS-1: digit data. In hex mode, bits [3:0] select the glyph; in raw mode, bits [6:0] are the segments.
REQ-016 Address map, address NUM_DIGITS: MODE mask, bit i=1 sets digit i to raw mode.
REQ-017 Address map, address NUM_DIGITS+1: BLINK mask, bit i=1 makes digit i blink.
REQ-018 Address map, address NUM_DIGITS+2: BLANK mask, bit i=1 forces digit i off.
REQ-019 Mask registers use only bits [NUM_DIGITS-1:0]; upper bits of wr_data are discarded.
REQ-020 Write handling: a write with wr_en=1 at edge k updates the shadow register at edge k and sets dirty at edge k.
REQ-021 Write to an address ≥ NUM_DIGITS+3: no state change; wr_err=1 for the cycle after edge k; dirty unaffected.
REQ-022 Commit: commit_req=1 at edge k copies all shadow registers to the active registers at edge k, clears dirty, and pulses commit_ack for the cycle after edge k.
REQ-023 Commit with commit_req held: one commit per edge sampled high, and commit_ack stays high correspondingly; the commit is idempotent.
REQ-024 Simultaneous write and commit at the same edge: the written value is forwarded into the active set, and dirty ends at 0.
REQ-025 Blink counter: counts 0..BLINK_DIV-1 and wraps to 0; on wrap, blink_phase toggles.
REQ-026 Display resolution, per digit i: BLANK[i]=1, or BLINK[i]=1 with blink_phase=1, gives all segments off. Otherwise MODE[i]=1 gives raw bits [6:0]; otherwise the hex decode of [3:0].
REQ-027 Hex decode (active-high gfedcba), 0-7: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
REQ-028 Hex decode (active-high gfedcba), 8-F: 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-029 ACTIVE_LOW=1: the resolved 7-bit value is inverted before registering.
REQ-030 Output latency: hex_out is registered from the active state, so a change to the active state at edge k appears on hex_out after edge k+1.
REQ-031 Shadow writes without a commit never alter hex_out.

Reset
REQ-032 rst_n=0 immediately clears, independent of clk: shadow and active registers, masks, blink counter, blink_phase, dirty, wr_err and commit_ack.
REQ-033 During reset, every hex_out digit drives "off": 7F when ACTIVE_LOW=1, 00 otherwise.
REQ-034 Reset asserted mid-write or mid-commit discards the operation; no partial commit survives.
REQ-035 After rst_n deasserts, the first rising edge behaves normally.

Verification
REQ-036 Defaults (ACTIVE_LOW=1): write addr0=0x08, commit -> commit_ack pulse; one cycle later hex_out[0]=0x00 and other digits=0x40.
REQ-037 Raw mode: write MODE=0x02 and addr1=0x49, commit -> hex_out[1]=0x36; dirty 1 before commit, 0 after.
REQ-038 Blink (BLINK_DIV=4): BLINK=0x01, addr0=0x01, committed -> hex_out[0] alternates 0x79 / 0x7F every 4 cycles.
REQ-039 Edge cases: write addr0=0x0A together with commit_req -> dirty=0, hex_out[0]=0x08 next cycle. Write addr=9 -> wr_err pulse, no state change.
REQ-040 Reset mid-operation: assert rst_n=0 between clock edges while dirty=1 -> outputs go off immediately, dirty=0, blink_phase=0.
